// File: rtl/vr16_pkg.sv
// vr16_pkg: shared types and defaults for the VR16 program-counter / jump unit.
package vr16_pkg;

    localparam int              PC_WIDTH_DEFAULT     = 16;
    localparam logic [15:0]     RESET_VECTOR_DEFAULT = 16'h0000;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        JUMP_FETCH = 2'd1,
        JUMP_DONE  = 2'd2
    } pc_state_t;

endpackage

// File: rtl/pc_jump_unit.sv
// pc_jump_unit: VR16 program counter plus jump sequencer handshaking a target fetch with instruction memory.
// Optional feature: define JUMP_RANGE_CHECK_EN to reject jump targets >= IMEM_DEPTH with a jump_fault pulse.
module pc_jump_unit
    import vr16_pkg::*;
#(
    parameter int                  PC_WIDTH     = PC_WIDTH_DEFAULT,
    parameter logic [PC_WIDTH-1:0] RESET_VECTOR = RESET_VECTOR_DEFAULT[PC_WIDTH-1:0],
    parameter int                  PC_STEP      = 1,
    parameter int                  IMEM_DEPTH   = 256
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable_pc_increment,
    input  logic                enable_jump,
    input  logic [PC_WIDTH-1:0] jump_address,
    input  logic                imem_ready,
    output logic [PC_WIDTH-1:0] pc,
    output logic                imem_req,
    output logic [PC_WIDTH-1:0] imem_addr,
    output logic                jump_done,
    output logic                busy,
    output logic                jump_fault
);

`ifdef JUMP_RANGE_CHECK_EN
    localparam logic LP_RANGE_CHECK = 1'b1;
`else
    localparam logic LP_RANGE_CHECK = 1'b0;
`endif

    localparam logic [PC_WIDTH:0]   LP_DEPTH = IMEM_DEPTH[PC_WIDTH:0];
    localparam logic [PC_WIDTH-1:0] LP_STEP  = PC_STEP[PC_WIDTH-1:0];

    pc_state_t           r_state;
    logic [PC_WIDTH-1:0] r_pc;
    logic [PC_WIDTH-1:0] r_imem_addr;
    logic                r_armed;
    logic                r_fault;
    logic                w_range_fault;

    // A target is rejected only when the range check is built in and it lies past the memory.
    assign w_range_fault = LP_RANGE_CHECK & ({1'b0, jump_address} >= LP_DEPTH);

    // FSM and PC register; a held enable_jump stays disarmed until it drops for a cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_pc        <= RESET_VECTOR;
            r_imem_addr <= RESET_VECTOR;
            r_armed     <= 1'b1;
            r_fault     <= 1'b0;
        end else begin
            r_armed <= !enable_jump ? 1'b1 : (r_state == JUMP_DONE) ? 1'b0 : r_armed;
            case (r_state)
                IDLE: begin
                    if (enable_jump && r_armed) begin
                        if (w_range_fault) begin
                            r_fault <= 1'b1;
                            r_state <= JUMP_DONE;
                        end else begin
                            r_pc        <= jump_address;
                            r_imem_addr <= jump_address;
                            r_state     <= JUMP_FETCH;
                        end
                    end else if (enable_pc_increment) begin
                        r_pc <= r_pc + LP_STEP;
                    end
                end
                JUMP_FETCH: begin
                    if (imem_ready) r_state <= JUMP_DONE;
                end
                JUMP_DONE: begin
                    r_fault <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Outputs decode straight from the state register so reset drops them immediately.
    always_comb begin
        pc         = r_pc;
        imem_addr  = r_imem_addr;
        imem_req   = (r_state == JUMP_FETCH);
        jump_done  = (r_state == JUMP_DONE);
        busy       = (r_state != IDLE);
        jump_fault = LP_RANGE_CHECK & r_fault & (r_state == JUMP_DONE);
    end

endmodule

// File: tb/tb_pc_jump_unit.sv
// tb_pc_jump_unit: directed self-checking bench for pc_jump_unit.
module tb_pc_jump_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable_pc_increment;
    logic        enable_jump;
    logic [15:0] jump_address;
    logic        imem_ready;
    logic [15:0] pc;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        jump_done;
    logic        busy;
    logic        jump_fault;

    int n_tests = 0;
    int n_fail  = 0;

    pc_jump_unit dut (
        .clk                 (clk),
        .reset               (reset),
        .enable_pc_increment (enable_pc_increment),
        .enable_jump         (enable_jump),
        .jump_address        (jump_address),
        .imem_ready          (imem_ready),
        .pc                  (pc),
        .imem_req            (imem_req),
        .imem_addr           (imem_addr),
        .jump_done           (jump_done),
        .busy                (busy),
        .jump_fault          (jump_fault)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Full jump: waits = number of cycles imem_ready stays low, with increment pulsed meanwhile.
    task automatic do_jump(input logic [15:0] tgt, input int waits);
        jump_address = tgt;
        enable_jump  = 1'b1;
        imem_ready   = 1'b0;
        @(negedge clk);
        check("jmp_pc", pc, tgt);
        check("jmp_req", imem_req, 1);
        check("jmp_addr", imem_addr, tgt);
        check("jmp_busy", busy, 1);
        for (int i = 0; i < waits; i++) begin
            enable_pc_increment = 1'b1;
            @(negedge clk);
            enable_pc_increment = 1'b0;
            check("wait_pc", pc, tgt);
            check("wait_addr", imem_addr, tgt);
            check("wait_req", imem_req, 1);
            check("wait_done", jump_done, 0);
        end
        imem_ready = 1'b1;
        @(negedge clk);
        check("done_pulse", jump_done, 1);
        check("done_req", imem_req, 0);
        check("done_fault", jump_fault, 0);
        imem_ready  = 1'b0;
        enable_jump = 1'b0;
        @(negedge clk);
        check("done_once", jump_done, 0);
        check("idle_busy", busy, 0);
        check("idle_pc", pc, tgt);
    endtask

    initial begin
        reset               = 1'b0;
        enable_pc_increment = 1'b0;
        enable_jump         = 1'b0;
        jump_address        = 16'h0000;
        imem_ready          = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_pc", pc, 16'h0000);
        check("rst_req", imem_req, 0);
        check("rst_done", jump_done, 0);
        check("rst_busy", busy, 0);
        check("rst_fault", jump_fault, 0);
        reset = 1'b1;
        @(negedge clk);
        enable_pc_increment = 1'b1;
        repeat (3) @(negedge clk);
        enable_pc_increment = 1'b0;
        @(negedge clk);
        check("inc3_pc", pc, 16'h0003);

        do_jump(16'hFFFF, 0);
        enable_pc_increment = 1'b1;
        @(negedge clk);
        enable_pc_increment = 1'b0;
        check("wrap_pc", pc, 16'h0000);

        do_jump(16'h0040, 0);
        do_jump(16'h0080, 3);

        do_jump(16'h0010, 0);
        enable_pc_increment = 1'b1;
        enable_jump         = 1'b1;
        jump_address        = 16'h0020;
        imem_ready          = 1'b1;
        @(negedge clk);
        enable_pc_increment = 1'b0;
        check("coll_pc", pc, 16'h0020);
        check("coll_req", imem_req, 1);
        @(negedge clk);
        check("coll_done", jump_done, 1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("hold_req", imem_req, 0);
            check("hold_done", jump_done, 0);
            check("hold_busy", busy, 0);
        end
        enable_jump = 1'b0;
        imem_ready  = 1'b0;
        @(negedge clk);
        do_jump(16'h0030, 1);

`ifdef JUMP_RANGE_CHECK_EN
        jump_address = 16'h0100;
        enable_jump  = 1'b1;
        @(negedge clk);
        check("rng_fault", jump_fault, 1);
        check("rng_done", jump_done, 1);
        check("rng_pc", pc, 16'h0030);
        check("rng_req", imem_req, 0);
        enable_jump = 1'b0;
        @(negedge clk);
        check("rng_fault_end", jump_fault, 0);
        check("rng_busy_end", busy, 0);
        check("rng_req_end", imem_req, 0);
`else
        do_jump(16'h0100, 0);
`endif

        jump_address = 16'h0050;
        enable_jump  = 1'b1;
        @(negedge clk);
        check("mid_req", imem_req, 1);
        #2 reset = 1'b0;
        #1;
        check("mid_rst_req", imem_req, 0);
        check("mid_rst_pc", pc, 16'h0000);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_addr", imem_addr, 16'h0000);
        enable_jump = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("post_rst_pc", pc, 16'h0000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
